adc_temp_avg: RTL and testbench
===============================

Name: adc_temp_avg

Overview:
- Downstream consumer of the on-chip ADC response stream (valid/channel/12-bit data) in the temperature-read design.
- Filters samples for one channel, discards a warm-up burst after reset, and box-car averages 2^LOG2_N samples.
- Writes each average into the single-port sample RAM as a circular log.
- Drives the board's 8 LEDs as a thermometer bar of the latest average.

Parameters:
- CHANNEL, 17, ADC channel number accepted (the temperature-sensing diode); other channels are ignored.
- LOG2_N, 4, log2 of samples per average (N=16); legal range 1..8.
- SKIP, 4, samples discarded after reset before accumulation starts; 0 is legal.
- ADDR_W, 8, RAM address width; log depth is 2^ADDR_W.

Ports:
- clk  in  1  system clock (same clock as the ADC CSR/response interface and RAM).
- rst  in  1  synchronous, active-high reset.
- adc_valid  in  1  response.valid strobe.
- adc_channel  in  5  response.channel.
- adc_data  in  12  response.data (unsigned).
- avg_valid  out  1  one-cycle pulse; avg_data is new.
- avg_data  out  12  latest average.
- ram_addr  out  ADDR_W  RAM write address.
- ram_data  out  12  RAM write data.
- ram_wren  out  1  RAM write enable, one cycle per average.
- log_wrapped  out  1  sticky; set once the write pointer wraps 2^ADDR_W-1 -> 0.
- led  out  8  thermometer bar of avg_data.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0 (led=8'h00); acc=0, cnt=0, skip_cnt=0, wr_ptr=0. State is SKIP, or ACCUM if SKIP=0.
- A sample is accepted when adc_valid=1 and adc_channel==CHANNEL. All other cycles are ignored, with no state change.
- State SKIP:
  - Each accepted sample increments skip_cnt.
  - On the SKIP-th accepted sample, go to ACCUM. That sample is discarded.
- State ACCUM:
  - acc is (12+LOG2_N) bits wide, so it never overflows.
  - On an accepted sample with cnt < N-1: acc += adc_data; cnt++.
  - On the accepted sample with cnt == N-1 (edge T):
    - sum_q <= acc + adc_data; done_q <= 1.
    - acc <= 0, cnt <= 0, so accumulation restarts with no lost cycle.
    - A sample accepted on the very next cycle counts as sample 0 of the next window.
- Output stage, on the edge after done_q (T+1):
  - avg_data <= sum_q >> LOG2_N (truncating).
  - avg_valid <= 1; ram_wren <= 1; ram_data <= same value; ram_addr <= wr_ptr.
  - wr_ptr <= wr_ptr + 1, modulo 2^ADDR_W.
  - If wr_ptr was all-ones, log_wrapped <= 1.
  - done_q <= 0.
- Latency: avg_valid/ram_wren are high in the cycle after edge T+1, i.e. 2 clocks after the last sample is sampled. They drop after exactly one cycle.
- led is updated on the same edge as avg_data. led[i] = (i <= avg_data[11:9]), so 1 to 8 LEDs are lit.
- Back-to-back windows require N >= 2 (guaranteed by LOG2_N >= 1), so output pulses never overlap.
- rst asserted mid-window or mid-output:
  - Partial sums and any pending done_q are dropped.
  - The pointer and log_wrapped clear.
  - The SKIP phase is re-entered.
- adc_data is treated as unsigned, with no saturation. Channel/valid values of X are the source's responsibility.

Optional Feature:
- Macro PEAK_HOLD_EN.
- When defined:
  - Adds output peak_data [11:0] (reset 0).
  - On each avg_valid edge, peak_data <= max(peak_data, new average).
  - When PEAK_HOLD_EN is defined, led shows the bar of peak_data instead of avg_data.
- When not defined: no peak_data port or register, and led follows avg_data.

Decomposition:
- Package read_temp_pkg holds:
  - ADC_DW=12 and CH_W=5.
  - The state enum {ST_SKIP, ST_ACCUM}.
  - Localparam CH_TSD=17.
- One sub-module, led_bar: 3-bit level in, registered 8-bit thermometer out, with enable and sync reset. It is instantiated once.

Test Plan:
- Reset, SKIP=4, LOG2_N=4: 4 channel-17 samples of 12'hFFF, then 16 samples of 12'h100.
  - Expect exactly one avg_valid, avg_data=12'h100, ram_addr=0.
  - Expect led=8'h01.
  - Skipped samples must not contribute.
- Interleave channel-3 samples of 12'hFFF with 16 channel-17 samples of 12'hA00.
  - Expect avg_data=12'hA00 and led=8'h3F; channel 3 ignored.
- Samples 0..15 with values 12'h000..12'h00F.
  - Expect avg_data=12'h007 (sum 120 >> 4, truncated).
  - Expect avg_valid exactly 2 clocks after the 16th valid.
- 257 consecutive windows (ADDR_W=8).
  - ram_addr runs 0..255 then 0.
  - log_wrapped rises on the 256th write and stays high.
- Assert rst for 1 cycle after 10 samples of a window, then feed 4+16 samples of 12'h800.
  - Expect no write from the aborted window, then avg_data=12'h800, ram_addr=0.
- With PEAK_HOLD_EN: windows averaging 12'h400, 12'hC00, 12'h200.
  - Expect peak_data 12'h400, 12'hC00, 12'hC00.
  - Expect led=8'h7F after the third window.

Source files
------------

// File: rtl/read_temp_pkg.sv
// Shared constants and FSM state type for the temperature-read datapath.
package read_temp_pkg;
  localparam int ADC_DW = 12;
  localparam int CH_W   = 5;
  localparam int CH_TSD = 17;

  typedef enum logic {ST_SKIP, ST_ACCUM} state_t;
endpackage

// File: rtl/adc_temp_avg_led_bar.sv
// Registered 8-LED thermometer bar: led i lights when i <= level, so 1..8 LEDs glow.
module led_bar (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] level,
  output logic [7:0] bar
);
  logic [7:0] therm;

  always_comb begin
    therm = '0;
    for (int i = 0; i < 8; i++) therm[i] = (3'(i) <= level);
  end

  always_ff @(posedge clk) begin
    if (rst)     bar <= '0;
    else if (en) bar <= therm;
  end
endmodule

// File: rtl/adc_temp_avg.sv
// Channel-filtered box-car averager with warm-up skip, circular RAM log and LED bar.
// Optional macro PEAK_HOLD_EN adds a peak_data register that the LED bar follows.
module adc_temp_avg
  import read_temp_pkg::*;
#(
  parameter int CHANNEL = CH_TSD,
  parameter int LOG2_N  = 4,
  parameter int SKIP    = 4,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_valid,
  input  logic [CH_W-1:0]   adc_channel,
  input  logic [ADC_DW-1:0] adc_data,
  output logic              avg_valid,
  output logic [ADC_DW-1:0] avg_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [ADC_DW-1:0] ram_data,
  output logic              ram_wren,
  output logic              log_wrapped,
`ifdef PEAK_HOLD_EN
  output logic [ADC_DW-1:0] peak_data,
`endif
  output logic [7:0]        led
);
  localparam int ACC_W = ADC_DW + LOG2_N;
  localparam state_t RST_STATE = (SKIP == 0) ? ST_ACCUM : ST_SKIP;

  // Handshake: a sample moves only in a cycle where adc_valid=1 and the channel
  // matches; there is no back-pressure, every other cycle leaves state untouched.
  state_t              state, state_next;
  logic                accept;
  logic                skip_inc, acc_add, win_done;
  logic [15:0]         skip_cnt;
  logic [LOG2_N-1:0]   cnt;
  logic [ACC_W-1:0]    acc, sum_q;
  logic                done_q;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADC_DW-1:0]   new_avg, bar_src;

  assign accept  = adc_valid && (adc_channel == CH_W'(CHANNEL));
  assign new_avg = ADC_DW'(sum_q >> LOG2_N);

  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == ST_SKIP && accept && skip_cnt == 16'(SKIP - 1))
      state_next = ST_ACCUM;
  end

  always_comb begin
    skip_inc = accept && (state == ST_SKIP);
    acc_add  = accept && (state == ST_ACCUM) && (cnt != '1);
    win_done = accept && (state == ST_ACCUM) && (cnt == '1);
  end

  // The closing sample goes straight into sum_q so the next window starts at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      skip_cnt <= '0;
      cnt      <= '0;
      acc      <= '0;
      sum_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= win_done;
      if (skip_inc) skip_cnt <= skip_cnt + 16'd1;
      if (acc_add) begin
        acc <= acc + ACC_W'(adc_data);
        cnt <= cnt + LOG2_N'(1);
      end
      if (win_done) begin
        sum_q <= acc + ACC_W'(adc_data);
        acc   <= '0;
        cnt   <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      avg_valid   <= 1'b0;
      avg_data    <= '0;
      ram_addr    <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      wr_ptr      <= '0;
      log_wrapped <= 1'b0;
    end else begin
      avg_valid <= done_q;
      ram_wren  <= done_q;
      if (done_q) begin
        avg_data <= new_avg;
        ram_data <= new_avg;
        ram_addr <= wr_ptr;
        wr_ptr   <= wr_ptr + ADDR_W'(1);
        if (&wr_ptr) log_wrapped <= 1'b1;
      end
    end
  end

`ifdef PEAK_HOLD_EN
  logic [ADC_DW-1:0] peak_next;
  assign peak_next = (new_avg > peak_data) ? new_avg : peak_data;
  assign bar_src   = peak_next;

  always_ff @(posedge clk) begin
    if (rst)         peak_data <= '0;
    else if (done_q) peak_data <= peak_next;
  end
`else
  assign bar_src = new_avg;
`endif

  led_bar u_led_bar (
    .clk  (clk),
    .rst  (rst),
    .en   (done_q),
    .level(bar_src[ADC_DW-1:ADC_DW-3]),
    .bar  (led)
  );
endmodule

// File: tb/tb_adc_temp_avg.sv
// Directed bench for adc_temp_avg with default parameters (ch 17, N=16, SKIP=4, 256-deep log).
module tb_adc_temp_avg;
  logic        clk, rst;
  logic        adc_valid;
  logic [4:0]  adc_channel;
  logic [11:0] adc_data;
  logic        avg_valid, ram_wren, log_wrapped;
  logic [11:0] avg_data, ram_data;
  logic [7:0]  ram_addr, led;
`ifdef PEAK_HOLD_EN
  logic [11:0] peak_data;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] avg;
    logic [11:0] data;
    logic [7:0]  addr;
    logic        wren;
    logic        wrap;
  } obs_t;

  obs_t        obs_q[$];
  logic [11:0] exp_q[$];
  logic [7:0]  exp_addr_q[$];
  logic        exp_wrap_q[$];

  adc_temp_avg dut (
    .clk        (clk),
    .rst        (rst),
    .adc_valid  (adc_valid),
    .adc_channel(adc_channel),
    .adc_data   (adc_data),
    .avg_valid  (avg_valid),
    .avg_data   (avg_data),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .log_wrapped(log_wrapped),
`ifdef PEAK_HOLD_EN
    .peak_data  (peak_data),
`endif
    .led        (led)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    adc_valid = 1'b0;
    adc_channel = '0;
    adc_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic [4:0] ch, input logic [11:0] d);
    adc_valid = 1'b1;
    adc_channel = ch;
    adc_data = d;
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [11:0] d);
    for (int i = 0; i < n; i++) send(5'd17, d);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_avg(input logic [11:0] a, input logic [7:0] ad, input logic wr);
    exp_q.push_back(a);
    exp_addr_q.push_back(ad);
    exp_wrap_q.push_back(wr);
  endtask

  // scoreboard: every output pulse is captured and matched in order
  always @(negedge clk) begin
    if (avg_valid) begin
      obs_t o;
      o.avg  = avg_data;
      o.data = ram_data;
      o.addr = ram_addr;
      o.wren = ram_wren;
      o.wrap = log_wrapped;
      obs_q.push_back(o);
    end
  end

  task automatic drain(input string tag);
    obs_t o;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      check({tag, "_avg"},  o.avg,  exp_q[0]);
      check({tag, "_data"}, o.data, exp_q.pop_front());
      check({tag, "_addr"}, o.addr, exp_addr_q.pop_front());
      check({tag, "_wren"}, o.wren, 1);
      check({tag, "_wrap"}, o.wrap, exp_wrap_q.pop_front());
    end
    obs_q.delete();
    exp_q.delete();
    exp_addr_q.delete();
    exp_wrap_q.delete();
  endtask

  initial begin
    do_reset();
    check("rst_avg_valid", avg_valid, 0);
    check("rst_avg_data", avg_data, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_ram_wren", ram_wren, 0);
    check("rst_wrapped", log_wrapped, 0);
    check("rst_led", led, 8'h00);

    // warm-up samples of FFF must be discarded
    send_n(4, 12'hFFF);
    send_n(16, 12'h100);
    expect_avg(12'h100, 8'd0, 1'b0);
    settle(4);
    drain("skip");
    check("skip_led", led, 8'h01);

    // other channel interleaved
    for (int i = 0; i < 16; i++) begin
      send(5'd3, 12'hFFF);
      send(5'd17, 12'hA00);
    end
    expect_avg(12'hA00, 8'd1, 1'b0);
    settle(4);
    drain("chan");
    check("chan_led", led, 8'h3F);

    // ramp 0..15: sum 120, truncated average 7; latency check
    for (int i = 0; i < 16; i++) send(5'd17, 12'(i));
    check("lat_t1", avg_valid, 0);
    @(negedge clk);
    check("lat_t2", avg_valid, 1);
    check("lat_wren", ram_wren, 1);
    @(negedge clk);
    check("lat_drop", avg_valid, 0);
    check("lat_wren_drop", ram_wren, 0);
    expect_avg(12'h007, 8'd2, 1'b0);
    settle(2);
    drain("ramp");
    check("ramp_led", led, 8'h01);

    // 257 back-to-back windows: pointer wraps, wrapped goes sticky on write to 255
    do_reset();
    send_n(4, 12'h000);
    for (int w = 0; w < 257; w++) begin
      send_n(16, 12'(w * 16));
      expect_avg(12'(w * 16), 8'(w), (w >= 255));
    end
    settle(4);
    drain("wrap");
    check("wrap_sticky", log_wrapped, 1);

    // abort a window with reset mid-way
    send_n(10, 12'hFFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_wrapped_clr", log_wrapped, 0);
    check("abort_addr_clr", ram_addr, 0);
    send_n(4, 12'h800);
    send_n(16, 12'h800);
    expect_avg(12'h800, 8'd0, 1'b0);
    settle(4);
    drain("abort");
    check("abort_led", led, 8'h1F);

`ifdef PEAK_HOLD_EN
    do_reset();
    check("peak_rst", peak_data, 0);
    send_n(4, 12'hFFF);
    send_n(16, 12'h400);
    settle(2);
    check("peak_1", peak_data, 12'h400);
    send_n(16, 12'hC00);
    settle(2);
    check("peak_2", peak_data, 12'hC00);
    send_n(16, 12'h200);
    settle(2);
    check("peak_3", peak_data, 12'hC00);
    check("peak_led", led, 8'h7F);
    check("peak_avg", avg_data, 12'h200);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
